// File: rtl/fpmul_result_capture_pkg.sv
// Shared definitions for the fpmul result capture block: float field layout,
// class codes and the buffered entry format.
package fpmul_result_capture_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MAN_W    = 23;
   localparam int unsigned EXP_POS  = 23;
   localparam int unsigned SIGN_BIT = 31;

   localparam logic [2:0] FPC_ZERO = 3'd0;
   localparam logic [2:0] FPC_SUB  = 3'd1;
   localparam logic [2:0] FPC_NORM = 3'd2;
   localparam logic [2:0] FPC_INF  = 3'd3;
   localparam logic [2:0] FPC_NAN  = 3'd4;

   typedef struct packed {
      logic [2:0]  cls;
      logic        omu;
      logic [31:0] data;
   } cap_entry_t;

   // Sign does not participate in the class; only exponent and mantissa do.
   function automatic logic [2:0] fp_class(input logic [EXP_W+MAN_W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[EXP_POS +: EXP_W];
      m = x[MAN_W-1:0];
      if (e == '0)      return (m == '0) ? FPC_ZERO : FPC_SUB;
      else if (e == '1) return (m == '0) ? FPC_INF  : FPC_NAN;
      else              return FPC_NORM;
   endfunction

endpackage

// File: rtl/fpmul_res_fifo.sv
// First-word-fall-through FIFO with a registered head word, level and full flag.
module fpmul_res_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            head,
   output logic                     vld,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic          push_ok;
   logic          pop_ok;
   logic [LW-1:0] level_next;
   logic [DW-1:0] head_next;

   // A pop frees a slot, so a push into a full FIFO is accepted when it pops too.
   always_comb begin
      pop_ok     = pop & vld;
      push_ok    = push & (~full | pop_ok);
      rd_next    = rd_ptr + AW'(1);
      level_next = level;
      if (push_ok & ~pop_ok)      level_next = level + LW'(1);
      else if (pop_ok & ~push_ok) level_next = level - LW'(1);
      head_next = head;
      if (pop_ok && (level > LW'(1)))               head_next = mem[rd_next];
      else if (push_ok && ((level == '0) || pop_ok)) head_next = din;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Head holds its last word while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         vld    <= 1'b0;
         full   <= 1'b0;
         head   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_next;
         level <= level_next;
         vld   <= (level_next != '0);
         full  <= (level_next == LW'(DEPTH));
         head  <= head_next;
      end
   end

endmodule

// File: rtl/fpmul_result_capture.sv
// Realigns fpmul issue tags with the product, classifies and buffers tagged
// results, and keeps sticky overflow and event counters.
module fpmul_result_capture
   import fpmul_result_capture_pkg::*;
#(
   parameter int unsigned LAT   = 1,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNTW  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_vld,
   input  logic [31:0]             c,
   input  logic                    omu,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [31:0]             out_data,
   output logic                    out_omu,
   output logic [2:0]              out_class,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf_err,
   output logic [CNTW-1:0]         drop_cnt,
   output logic [CNTW-1:0]         omu_cnt,
   input  logic                    clr_err
);
   logic [LAT-1:0] tag_pipe;
   logic           tag_out;
   logic           full;
   logic           drop;
   cap_entry_t     entry;
   cap_entry_t     head;

   assign tag_out = tag_pipe[LAT-1];

   always_comb begin
      entry      = '0;
      entry.cls  = fp_class(c);
      entry.omu  = omu;
      entry.data = c;
      // Full implies a valid head, so only out_rdy can rescue the push.
      drop       = tag_out & full & ~out_rdy;
   end

   fpmul_res_fifo #(
      .DEPTH (DEPTH),
      .DW    ($bits(cap_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_out),
      .pop   (out_rdy),
      .din   (entry),
      .head  (head),
      .vld   (out_vld),
      .full  (full),
      .level (level)
   );

   assign out_data  = head.data;
   assign out_omu   = head.omu;
   assign out_class = head.cls;

   // Tag pipe and saturating counters; a drop coinciding with clr_err wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_pipe <= '0;
         ovf_err  <= 1'b0;
         drop_cnt <= '0;
         omu_cnt  <= '0;
      end else begin
         tag_pipe <= LAT'({tag_pipe, issue_vld});
         if (drop) begin
            ovf_err  <= 1'b1;
            drop_cnt <= clr_err ? CNTW'(1)
                      : ((drop_cnt != '1) ? drop_cnt + CNTW'(1) : drop_cnt);
         end else if (clr_err) begin
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
         end
         if (tag_out && omu && (omu_cnt != '1)) omu_cnt <= omu_cnt + CNTW'(1);
      end
   end

endmodule

// File: doc/fpmul_result_capture.md
Name: fpmul_result_capture

Overview:
- Downstream companion of fpmul.
- Tracks which fpmul input cycles carry real operands and realigns that valid tag with the fixed-latency product on c / over_mul_under.
- Classifies each product and buffers it in a small FIFO with a valid/ready output handshake.
- Keeps sticky error and event counters for the test benches and any consumer datapath.

Parameters:
- LAT, 1, fpmul latency in clk cycles from operand edge to result on c (≥1)
- DEPTH, 8, result FIFO entries (power of two, ≥2)
- CNTW, 16, width of the saturating event counters

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  synchronous reset, active-high
- issue_vld  in  1  a/b driven to fpmul this cycle are a real operation
- c  in  32  fpmul product
- omu  in  1  fpmul over_mul_under flag
- out_vld  out  1  FIFO head valid
- out_rdy  in  1  consumer accepts head
- out_data  out  32  head product
- out_omu  out  1  head over/underflow flag
- out_class  out  3  head class code
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf_err  out  1  sticky: a result was dropped on a full FIFO
- drop_cnt  out  CNTW  saturating count of dropped results
- omu_cnt  out  CNTW  saturating count of tagged results with omu=1
- clr_err  in  1  clears ovf_err and drop_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: tag pipe 0, FIFO empty, out_vld 0, out_data 0, out_omu 0, out_class 0, level 0, ovf_err 0, drop_cnt 0, omu_cnt 0.
- Reset mid-operation: in-flight tags and buffered entries are discarded; nothing from before reset ever reaches the output.
- Tag pipe:
  - LAT-deep shift register of issue_vld.
  - tag_out = issue_vld delayed LAT edges. It is asserted in the cycle when c holds that operation's product.
- Capture: on an edge with tag_out=1, entry {class(c), omu, c} is pushed.
- Class codes, from c[30:23] (exp) and c[22:0] (man):
  - exp=0, man=0 → ZERO=0
  - exp=0, man≠0 → SUB=1
  - 0<exp<255 → NORM=2
  - exp=255, man=0 → INF=3
  - exp=255, man≠0 → NAN=4
  - Codes 5-7 are unused.
- FIFO:
  - First-word-fall-through. out_* show the head whenever out_vld=1; out_vld = (level≠0).
  - Pop on an edge with out_vld & out_rdy.
  - Push into an empty FIFO becomes visible the next cycle; there is no same-cycle bypass.
  - Push and pop in the same cycle: level unchanged, including when full (the pop frees the slot, so no drop).
  - Push while full without a pop: entry dropped, ovf_err←1, drop_cnt+1 saturating at all-ones.
  - Pointers wrap modulo DEPTH.
  - out_data and out_omu hold their last value while out_vld=0.
- omu_cnt: +1 saturating on every tagged capture with omu=1, whether or not the entry is dropped.
- clr_err:
  - Clears ovf_err and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, the drop wins: ovf_err=1, drop_cnt=1.
  - Does not affect omu_cnt.
- Untagged cycles: c and omu are ignored entirely.
- Throughput: one capture per cycle sustained. No backpressure reaches fpmul; overflow is reported, never stalled.

Decomposition:
- fpmath_defs.v gains:
  - class code constants FPC_ZERO, FPC_SUB, FPC_NORM, FPC_INF, FPC_NAN
  - single-precision field widths and positions: EXP_W=8, MAN_W=23, sign bit 31
- One natural sub-module: fpmul_res_fifo, a synchronous-reset FWFT FIFO parameterized on DEPTH and data width (36 bits: class, omu, c), exposing level and full.
- Tag pipe, classifier and counters stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles with issue_vld=1 → all outputs 0, and no entry appears for LAT cycles after release.
- Basic path, LAT=1: issue a=3f800000, b=40000000 → one cycle later c=40000000. The cycle after, out_vld=1, out_data=40000000, out_class=2, out_omu=0. Pop with out_rdy=1 → level 0.
- Fill and overflow: 9 back-to-back issues of distinct products with out_rdy=0 → level=8, ovf_err=1, drop_cnt=1. Draining yields the first 8 products in issue order. clr_err → ovf_err=0, drop_cnt=0.
- Full plus simultaneous push/pop: FIFO full, out_rdy=1, issue continuously → level stays 8, drop_cnt stays 0, order preserved.
- Overflow product and classes: a=7f000000, b=7f000000 → omu=1, c=7f800000, out_class=3, omu_cnt=1. Inject c=7fc00000 → class 4. Inject c=00000001 → class 1. Inject c=0 → class 0.
- Counter saturation and clr_err collision: force drop_cnt to all-ones, drop again → value holds. Assert clr_err in the same cycle as a drop → drop_cnt=1, ovf_err=1.
